i2c_write_master: RTL

Bit-level I2C write engine that serialises one 24-bit word {slave address, register address, data} as a START, three bytes each followed by an ACK slot, and a STOP. It sits directly downstream of the WM8731 audio-config sequencer, which supplies the word plus a go level and waits for done. All timing is derived from the 10 kHz controller clock. SDAT is open-drain; SCLK is driven push-pull.

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_write_master_if.sv | 28 ++
 rtl/i2c_write_master.sv | 123 ++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C write engine.
// One transfer: START, 3 x (8 data + ACK) slots, STOP.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    STOP,
    DONE
  } state_t;

  typedef logic [23:0] word_t;

  localparam int PHASES        = 4;
  localparam int BITS_PER_BYTE = 9;
  localparam int N_BYTES       = 3;
  localparam int XFER_CYCLES   = 116;

  localparam logic [7:0] WM8731_ADDR = 8'h34;

endpackage

// File: rtl/i2c_write_master_if.sv
// Request/response bundle between the config sequencer
// (master) and the I2C write engine (slave).
interface i2c_write_master_if;
  import i2c_pkg::*;

  word_t      i2c_data;
  logic       go;
  logic       done;
  logic [2:0] ack;
  logic       busy;

  modport master (
    output i2c_data,
    output go,
    input  done,
    input  ack,
    input  busy
  );

  modport slave (
    input  i2c_data,
    input  go,
    output done,
    output ack,
    output busy
  );

endinterface

// File: rtl/i2c_write_master.sv
// Bit-level I2C write engine: START, three bytes with ACK
// slots, STOP. Four controller cycles per bit slot.
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter bit NACK_ABORT = 1'b0
) (
  input  logic              clk_i2c,
  input  logic              reset_n,
  i2c_write_master_if.slave hs,
  output logic              i2c_sclk,
  inout  wire               i2c_sdat
);

  localparam logic [1:0] LAST_PH   = 2'(PHASES - 1);
  localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);
  localparam logic [1:0] LAST_BYTE = 2'(N_BYTES - 1);

  state_t     state_q;
  logic [1:0] ph_q;
  logic [3:0] bit_q;
  logic [1:0] byte_q;
  word_t      sr_q;
  logic       scl_q;
  logic       sda_lo_q;
  logic       busy_q;
  logic       done_q;
  logic [2:0] ack_q;

  logic       ack_slot;
  logic [1:0] ack_idx;

  assign ack_slot = (bit_q == LAST_BIT);
  assign ack_idx  = LAST_BYTE - byte_q;

  // Outputs are registered for the phase being entered.
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sr_q     <= '0;
      scl_q    <= 1'b1;
      sda_lo_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ack_q    <= '0;
    end else begin
      ph_q <= ph_q + 2'd1;
      unique case (state_q)
        IDLE: begin
          ph_q     <= '0;
          scl_q    <= 1'b1;
          sda_lo_q <= 1'b0;
          done_q   <= 1'b0;
          if (hs.go) begin
            sr_q    <= hs.i2c_data;
            ack_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (ph_q == 2'd0) sda_lo_q <= 1'b1;
          if (ph_q == 2'd2) scl_q <= 1'b0;
          if (ph_q == LAST_PH) begin
            state_q  <= BITS;
            sda_lo_q <= ~sr_q[23];
          end
        end
        BITS: begin
          if (ph_q == 2'd0) scl_q <= 1'b1;
          if (ph_q == 2'd2) begin
            scl_q <= 1'b0;
            if (ack_slot) ack_q[ack_idx] <= i2c_sdat;
          end
          if (ph_q == LAST_PH) begin
            if (!ack_slot) begin
              sr_q     <= sr_q << 1;
              bit_q    <= bit_q + 4'd1;
              sda_lo_q <= (bit_q == LAST_BIT - 4'd1)
                          ? 1'b0 : ~sr_q[22];
            end else if (byte_q == LAST_BYTE ||
                         (NACK_ABORT && ack_q[ack_idx])) begin
              state_q  <= STOP;
              sda_lo_q <= 1'b1;
            end else begin
              byte_q   <= byte_q + 2'd1;
              bit_q    <= '0;
              sda_lo_q <= ~sr_q[23];
            end
          end
        end
        STOP: begin
          if (ph_q == 2'd0) scl_q <= 1'b1;
          if (ph_q == 2'd2) sda_lo_q <= 1'b0;
          if (ph_q == LAST_PH) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          ph_q <= '0;
          if (!hs.go) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign i2c_sclk = scl_q;
  assign i2c_sdat = sda_lo_q ? 1'b0 : 1'bz;
  assign hs.done  = done_q;
  assign hs.busy  = busy_q;
  assign hs.ack   = ack_q;

endmodule
